// File: rtl/simon_playback.sv
// Simon playback sequencer: walks pattern memory entries 0..len-1, showing each
// pattern on the LEDs for ON_CYCLES cycles followed by OFF_CYCLES blank cycles.
module simon_playback #(
   parameter int ADDR_W     = 6,
   parameter int DATA_W     = 4,
   parameter int ON_CYCLES  = 4,
   parameter int OFF_CYCLES = 2
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_abort,
   input  logic [ADDR_W-1:0] i_len,
   output logic [ADDR_W-1:0] o_rd_addr,
   input  logic [DATA_W-1:0] i_rd_data,
   output logic [DATA_W-1:0] o_leds,
   output logic              o_busy,
   output logic              o_done
);

   typedef enum logic [1:0] {IDLE, SHOW, GAP, FIN} state_t;

   localparam logic [15:0]       ON_LAST  = 16'(ON_CYCLES - 1);
   localparam logic [15:0]       OFF_LAST = 16'(OFF_CYCLES - 1);
   localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

   state_t            r_state;
   logic [ADDR_W-1:0] r_idx;
   logic [ADDR_W-1:0] r_len_q;
   logic [15:0]       r_tmr;
   logic              r_busy;
   logic              r_done;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_len_q <= '0;
         r_tmr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else if (i_abort && r_state != IDLE) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_tmr   <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_len_q <= i_len;
                  r_idx   <= '0;
                  r_tmr   <= '0;
                  r_busy  <= 1'b1;
                  if (i_len != '0) begin
                     r_state <= SHOW;
                  end else begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end
               end
            end
            SHOW: begin
               if (r_tmr == ON_LAST) begin
                  r_tmr   <= '0;
                  r_state <= GAP;
               end else begin
                  r_tmr <= r_tmr + 16'd1;
               end
            end
            GAP: begin
               if (r_tmr == OFF_LAST) begin
                  r_tmr <= '0;
                  // Last-entry check precedes the increment, so idx never passes len-1.
                  if (r_idx == r_len_q - ONE) begin
                     r_state <= FIN;
                     r_done  <= 1'b1;
                  end else begin
                     r_idx   <= r_idx + ONE;
                     r_state <= SHOW;
                  end
               end else begin
                  r_tmr <= r_tmr + 16'd1;
               end
            end
            FIN: begin
               r_state <= IDLE;
               r_idx   <= '0;
               r_busy  <= 1'b0;
               r_done  <= 1'b0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign o_rd_addr = r_idx;
   assign o_busy    = r_busy;
   assign o_done    = r_done;
   assign o_leds    = (r_state == SHOW) ? i_rd_data : '0;

endmodule

// File: tb/tb_simon_playback.sv
// Randomized bench for simon_playback: a cycle-offset model derived from the
// playback timeline predicts leds/rd_addr/busy/done for every cycle of a run.
module tb_simon_playback;

   localparam int ON  = 4;
   localparam int OFF = 2;
   localparam int P   = ON + OFF;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       abort;
   logic [5:0] len;
   logic [5:0] rd_addr;
   logic [3:0] rd_data;
   logic [3:0] leds;
   logic       busy;
   logic       done;

   logic [3:0] mem [64];
   int         n_chk = 0;
   int         n_bad = 0;
   int         peak_addr;

   assign rd_data = mem[rd_addr];

   always #5 clk = ~clk;

   simon_playback #(.ADDR_W(6), .DATA_W(4), .ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_len(len),
      .o_rd_addr(rd_addr), .i_rd_data(rd_data), .o_leds(leds), .o_busy(busy), .o_done(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s t=%0t obs=%0h exp=%0h", tag, $time, obs, exp);
      end
   endtask

   // Play a run of length L; abort raised in cycle ab, start re-pulsed in cycle rs (-1 = never).
   task automatic run_play(input int L, input int ab, input int rs);
      int  endt;
      int  k;
      bit  gone;
      logic [3:0] e_leds;
      logic [5:0] e_addr;
      logic       e_busy, e_done;
      endt = L * P;
      gone = 1'b0;
      @(negedge clk);
      start = 1'b1;
      len   = 6'(L);
      @(negedge clk);
      start = 1'b0;
      len   = 6'($urandom);
      for (int t = 0; t <= endt + 2; t++) begin
         if (t > 0) @(negedge clk);
         if (gone || t > endt) begin
            e_leds = '0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0;
         end else if (t == endt) begin
            e_leds = '0; e_addr = (L == 0) ? 6'd0 : 6'(L - 1); e_busy = 1'b1; e_done = 1'b1;
         end else begin
            k = t / P;
            e_leds = ((t % P) < ON) ? mem[k] : 4'd0;
            e_addr = 6'(k);
            e_busy = 1'b1;
            e_done = 1'b0;
         end
         chk("leds", 32'(leds), 32'(e_leds));
         chk("rd_addr", 32'(rd_addr), 32'(e_addr));
         chk("busy", 32'(busy), 32'(e_busy));
         chk("done", 32'(done), 32'(e_done));
         if (32'(rd_addr) > 32'(peak_addr)) peak_addr = int'(rd_addr);
         start = (!gone && t == rs && t <= endt);
         if (start) len = 6'd5;
         abort = (!gone && t == ab && t <= endt);
         if (abort) gone = 1'b1;
      end
      abort = 1'b0;
      start = 1'b0;
   endtask

   initial begin
      int L, ab, rs;
      rst = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
      for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);
      mem[0] = 4'b0001; mem[1] = 4'b0100; mem[2] = 4'b1000;
      #2;
      chk("rst_leds", 32'(leds), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_addr", 32'(rd_addr), 0);
      @(negedge clk);
      rst = 1'b0;

      // Asynchronous reset in the middle of entry 1's show window
      @(negedge clk);
      start = 1'b1; len = 6'd3;
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      chk("pre_rst_leds", 32'(leds), 32'(mem[1]));
      #2 rst = 1'b1;
      #1;
      chk("arst_leds", 32'(leds), 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_done", 32'(done), 0);
      @(negedge clk);
      rst = 1'b0;
      run_play(1, -1, -1);

      run_play(3, -1, -1);          // normal 3-entry playback
      run_play(0, -1, -1);          // zero length
      run_play(3, 5, -1);           // abort in gap after entry 0
      run_play(0, 0, -1);           // abort while FIN is active
      run_play(2, -1, 3);           // start re-pulse ignored while busy

      for (int i = 0; i < 64; i++) mem[i] = 4'(i);
      peak_addr = 0;
      run_play(63, -1, -1);
      chk("peak_addr", 32'(peak_addr), 62);

      for (int n = 0; n < 8; n++) begin
         for (int i = 0; i < 64; i++) mem[i] = 4'($urandom);
         L  = int'($urandom_range(0, 12));
         ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L * P)) : -1;
         rs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, L * P)) : -1;
         run_play(L, ab, rs);
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout t=%0t", $time);
      $fatal(1);
   end

endmodule

// File: doc/simon_playback.md
# simon_playback

Playback sequencer for the Simon game. It reads the stored pattern sequence out of the 64-entry pattern memory, from entry 0 through the last entry. It drives each 4-bit pattern onto the LEDs for a fixed on-time, followed by a blank gap. The game controller starts it with a one-cycle request and receives a one-cycle completion pulse; the datapath keeps write access to the memory while the sequencer owns the read port during playback.

## Interface

- ADDR_W, 6, memory address width (64 entries)
- DATA_W, 4, pattern width
- ON_CYCLES, 4, cycles each pattern is shown (must be ≥1)
- OFF_CYCLES, 2, blank cycles after each pattern (must be ≥1)

Ports (one clock; `reset` is asynchronous and active-high):

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; forces IDLE
- start  in  1  playback request, sampled only in IDLE
- abort  in  1  synchronous cancel; returns to IDLE without `done`
- len  in  ADDR_W  number of entries to play; sampled with `start`
- rd_addr  out  ADDR_W  memory read address (registered)
- rd_data  in  DATA_W  memory read data, combinational from `rd_addr`
- leds  out  DATA_W  LED drive
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse

## Operation

- States:
  - IDLE: `busy`=0, `leds`=0, `rd_addr`=0.
  - SHOW: `leds`=`rd_data`.
  - GAP: `leds`=0.
  - FIN: `done`=1, `leds`=0.
- Internal registers:
  - `idx` (ADDR_W bits), driven directly to `rd_addr`.
  - `len_q` (ADDR_W bits), holds the sampled `len`.
  - `tmr` (16 bits), counts cycles in SHOW and GAP.
- IDLE, `start`=1:
  - Latch `len_q`=`len` and set `idx`=0, `tmr`=0.
  - If `len`≠0, go to SHOW; if `len`=0, go to FIN.
- SHOW:
  - `tmr` increments each cycle.
  - When `tmr`=ON_CYCLES-1: clear `tmr`, go to GAP.
- GAP:
  - `tmr` increments each cycle.
  - When `tmr`=OFF_CYCLES-1: clear `tmr`.
  - Then, if `idx`=`len_q`-1, go to FIN.
  - Otherwise increment `idx` and go to SHOW.
- FIN: stays one cycle, then goes to IDLE unconditionally.
- `start` outside IDLE is ignored. `len` changes after sampling are ignored.
- `abort`=1 in SHOW, GAP or FIN:
  - Next state is IDLE; `idx` and `tmr` clear.
  - `done` is not pulsed. If FIN is already active in that cycle, its `done` still shows.
  - `abort` has priority over every other transition. `abort` in IDLE has no effect, including when `start`=1 in the same cycle.
- `len`=2^ADDR_W-1 plays entries 0..62. `len`=0 means nothing to play; entry 63 is never shown.
- `idx` never wraps: the FIN check fires before any increment past `len_q`-1.
- `leds` is decoded combinationally from state and `rd_data`. All other outputs are registered or decoded from state.

## Timing

- Reset values (asynchronous assert, released on next clk):
  - state=IDLE; `rd_addr`=0; `leds`=0; `busy`=0; `done`=0.
  - `idx`, `tmr` and `len_q` all 0.
- Let E0 be the edge that samples `start`=1 in IDLE.
- Entry k (0-based):
  - Shown from edge E0+k·(ON+OFF) for ON_CYCLES cycles.
  - Blank for the following OFF_CYCLES cycles.
- `done` is high for exactly the cycle starting at E0+len·(ON+OFF). With `len`=0 this is the cycle after E0.
- `busy` rises at E0 and falls at the edge ending the FIN cycle.
- Earliest next `start` is sampled in the cycle after FIN.
- `rd_addr` updates on the edge that enters SHOW for the new entry, so `leds` is valid in the first SHOW cycle.
- `reset` asserted mid-playback:
  - `leds`, `busy` and `done` go to 0 immediately, without waiting for clk.
  - No `done` is pulsed.

## Test plan

- **Reset mid-show:** assert `reset` during SHOW of entry 1.
  - `leds`/`busy` drop to 0 asynchronously.
  - After release, `start` with `len`=1 plays entry 0 normally.
- **Normal 3-entry playback:** memory {0001, 0100, 1000}, `len`=3, ON=4, OFF=2.
  - `leds` pattern: 0001×4, 0×2, 0100×4, 0×2, 1000×4, 0×2.
  - `done` high exactly at E0+18; `busy` high E0..E0+19.
- **Zero length:** `len`=0.
  - `done` high in the cycle after E0.
  - `leds` stays 0; `rd_addr` stays 0.
- **Abort:** `abort` pulsed in GAP after entry 0 of a 3-entry run.
  - IDLE next cycle; `done` never asserts; `rd_addr`=0.
- **Start and len changes while busy:** `start` re-pulsed with `len`=5 during playback of a `len`=2 run.
  - Ignored; exactly 2 entries play and `done` comes at E0+12.
- **Maximum length:** `len`=63, memory[k]=k[3:0].
  - Entries 0..62 play in order; `rd_addr` peaks at 62; `done` at E0+378.
